fifo_rd_packer: RTL and testbench
=================================

# fifo_rd_packer

Read-side consumer placed directly downstream of the async FIFO in the read clock domain. Pops W-bit words from the FIFO's first-word-fall-through read port (RD_FAST=1: read data valid whenever empty is low) and packs RATIO consecutive words into one wide beat on a valid/ready output stream. A flush request emits a partially filled beat with a byte-lane keep mask, so tail data never stalls in the packer.

## Interface
- W, 8: FIFO word width in bits.
- RATIO, 4: words per output beat; legal values 2, 4, 8, 16.
- CW, derived: counter width, log2(RATIO)+1.
- rd_clk  in  1  read-domain clock, shared with the FIFO read side.
- rd_reset  in  1  asynchronous, active-high reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_data  in  W  FIFO head word, valid while fifo_empty=0.
- fifo_rd_en  out  1  pop strobe to the FIFO, combinational.
- flush  in  1  single-cycle pulse requesting emission of a partial beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  W*RATIO  packed beat; first-popped word in bits [W-1:0].
- out_keep  out  RATIO  per-word valid mask, LSB = word 0.
- busy  out  1  high while cnt≠0, a flush is pending, or out_valid=1.

## Operation
- State: accumulator acc[W*RATIO], fill count cnt (0..RATIO-1), flush_pend flag, and output register (out_data, out_keep, out_valid).
- out_free = !out_valid || out_ready.
- Pop rule: fifo_rd_en = !rd_reset && !fifo_empty && (cnt<RATIO-1 || out_free).
  - fifo_rd_en is never asserted while fifo_empty=1. Underflow is impossible by construction.
- On a pop, fifo_rd_data is written into acc lane cnt.
- Completion:
  - A pop with cnt==RATIO-1 loads the output register with acc plus the new word, sets out_keep to all ones, and returns cnt to 0.
  - This path is only possible when out_free=1.
- Flush:
  - A flush pulse sets flush_pend. The flag stays set until serviced.
  - Service condition: flush_pend && out_free && (filled words this cycle > 0).
  - "Filled words this cycle" is cnt plus 1 if a pop occurs in the same cycle.
  - On service, the output register loads acc including any same-cycle pop word. out_keep has the low (filled) bits set. Unfilled lanes of out_data are 0. cnt returns to 0 and flush_pend clears.
  - If flush_pend is set and zero words are held, flush_pend clears with no beat emitted.
  - If the same-cycle pop completes a full beat, that beat uses the normal path (keep all ones) and flush_pend clears.
- Output handshake:
  - out_valid stays high, with out_data and out_keep stable, until out_ready=1.
  - Back-to-back beats are allowed: a new beat may load in the same cycle the current beat is accepted.
- acc lanes are cleared to 0 after each emission.
- Reset may assert mid-beat. It discards acc, cnt, flush_pend, and any unaccepted output beat. The FIFO is reset in the same domain, so no data is orphaned.

## Timing
- Reset values: out_valid=0, out_data=0, out_keep=0, busy=0, fifo_rd_en=0. Internal state: cnt=0, flush_pend=0.
- Pop latency: a word is popped in the same cycle it is visible (fifo_empty=0).
- Beat latency: out_valid rises on the rd_clk edge that performs the RATIO-th pop. The beat is visible in the cycle after that pop.
- Sustained throughput: one word per cycle while out_ready=1 and the FIFO is non-empty. This gives one beat every RATIO cycles with no bubbles.
- Backpressure: with out_valid=1 and out_ready=0, popping continues until cnt==RATIO-1. Popping then stops and at most RATIO-1 words are held in acc.
- Flush latency: a flush pulse with cnt>0 and out_free=1 produces out_valid on the next edge. If out_free=0, emission waits until the first cycle with out_ready=1.
- Flush pulses arriving while flush_pend=1 merge into the pending flush.

## Test plan
- Basic packing (RATIO=4, W=8): FIFO presents 0x11, 0x22, 0x33, 0x44 back-to-back with out_ready=1. Required: one beat, out_data=0x44332211, out_keep=4'b1111, out_valid high one cycle after the 4th pop.
- Backpressure: hold out_ready=0 after the first beat while 7 more words are queued. Required: exactly 3 further pops, then fifo_rd_en=0. Raising out_ready yields the second beat the next cycle.
- Partial flush: pop 0xAA, 0xBB, then pulse flush. Required: out_data=0x0000BBAA, out_keep=4'b0011, cnt=0, busy=0 after acceptance.
- Flush coincident with pop: pulse flush in the same cycle as the 3rd pop (0xC3). Required: out_keep=4'b0111, with 0xC3 in lane 2. Flush with empty accumulator: no beat, busy stays 0.
- Empty gaps: fifo_empty toggles every other cycle. Required: fifo_rd_en never high while fifo_empty=1, and beat contents remain in order.
- Reset mid-beat: assert rd_reset with cnt=2 and out_valid=1. Required: all outputs at reset values immediately. The next four words produce a clean, fully kept beat.

Source files
------------

// File: rtl/fifo_rd_packer_if.sv
// Bundle between the packer, the FIFO read port and the downstream wide stream.
// The packer uses the slave modport; whatever drives the FIFO side and the stream sink uses master.
interface fifo_rd_packer_if #(
  parameter int unsigned W     = 8,
  parameter int unsigned RATIO = 4
);
  logic                 fifo_empty;
  logic [W-1:0]         fifo_rd_data;
  logic                 fifo_rd_en;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [W*RATIO-1:0]   out_data;
  logic [RATIO-1:0]     out_keep;
  logic                 busy;

  modport slave (
    input  fifo_empty, fifo_rd_data, flush, out_ready,
    output fifo_rd_en, out_valid, out_data, out_keep, busy
  );

  modport master (
    output fifo_empty, fifo_rd_data, flush, out_ready,
    input  fifo_rd_en, out_valid, out_data, out_keep, busy
  );
endinterface

// File: rtl/fifo_rd_packer.sv
// Pops FWFT FIFO words and packs RATIO of them into one wide valid/ready beat.
// A flush emits a partial beat with a per-word keep mask.
module fifo_rd_packer #(
  parameter int unsigned W     = 8,
  parameter int unsigned RATIO = 4
) (
  input  logic              rd_clk_i,
  input  logic              rd_reset_i,
  fifo_rd_packer_if.slave   bus
);
  localparam int unsigned CW = $clog2(RATIO) + 1;
  localparam int unsigned BW = W * RATIO;

  logic [CW-1:0]    cnt_q, cnt_d, filled;
  logic [BW-1:0]    acc_q, acc_d, acc_w;
  logic [BW-1:0]    out_data_q, out_data_d;
  logic [RATIO-1:0] out_keep_q, out_keep_d, part_keep;
  logic             out_valid_q, out_valid_d;
  logic             flush_pend_q, flush_pend_d;
  logic             out_free, pop, pend, complete;

  always_comb begin
    out_free = !out_valid_q || bus.out_ready;
    pop      = !rd_reset_i && !bus.fifo_empty &&
               ((cnt_q < CW'(RATIO - 1)) || out_free);
    filled   = cnt_q + {{(CW-1){1'b0}}, pop};
    complete = pop && (cnt_q == CW'(RATIO - 1));
    pend     = flush_pend_q || bus.flush;

    // acc_w is the accumulator including any word popped this cycle
    acc_w     = acc_q;
    part_keep = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (pop && (cnt_q == CW'(i)))
        acc_w[i*W +: W] = bus.fifo_rd_data;
      part_keep[i] = (CW'(i) < filled);
    end

    cnt_d        = cnt_q;
    acc_d        = acc_q;
    out_data_d   = out_data_q;
    out_keep_d   = out_keep_q;
    out_valid_d  = out_valid_q && !bus.out_ready;
    flush_pend_d = pend;

    if (complete) begin
      out_data_d   = acc_w;
      out_keep_d   = '1;
      out_valid_d  = 1'b1;
      cnt_d        = '0;
      acc_d        = '0;
      flush_pend_d = 1'b0;
    end else if (pend && out_free && (filled != '0)) begin
      out_data_d   = acc_w;
      out_keep_d   = part_keep;
      out_valid_d  = 1'b1;
      cnt_d        = '0;
      acc_d        = '0;
      flush_pend_d = 1'b0;
    end else begin
      acc_d = acc_w;
      cnt_d = filled;
      // a flush with nothing held is simply dropped
      if (filled == '0)
        flush_pend_d = 1'b0;
    end
  end

  always_ff @(posedge rd_clk_i or posedge rd_reset_i) begin
    if (rd_reset_i) begin
      cnt_q        <= '0;
      acc_q        <= '0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      out_valid_q  <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
      out_valid_q  <= out_valid_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign bus.fifo_rd_en = pop;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_keep   = out_keep_q;
  assign bus.busy       = (cnt_q != '0) || flush_pend_q || out_valid_q;
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Randomized bench for fifo_rd_packer against a queue-based reference model.
module tb_fifo_rd_packer;
  localparam int W  = 8;
  localparam int R  = 4;
  localparam int BW = W * R;

  logic rd_clk;
  logic rd_reset;

  fifo_rd_packer_if #(.W(W), .RATIO(R)) bus ();

  fifo_rd_packer #(.W(W), .RATIO(R)) dut (
    .rd_clk_i   (rd_clk),
    .rd_reset_i (rd_reset),
    .bus        (bus)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  int n_vec;
  int n_err;
  int dut_pops;

  logic [W-1:0]  src[$];
  logic [W-1:0]  held[$];
  bit            m_pend;
  bit            m_ov;
  logic [BW-1:0] m_od;
  logic [R-1:0]  m_keep;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_words(input int n, input int base);
    for (int k = 0; k < n; k++) begin
      logic [W-1:0] w;
      w = (base < 0) ? W'($urandom) : W'(base + k);
      src.push_back(w);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, check, then advance the model.
  task automatic step(input bit rdy, input bit fl, input bit gap);
    bit empty, free, pop, pend;
    bus.out_ready    = rdy;
    bus.flush        = fl;
    empty            = gap || (src.size() == 0);
    bus.fifo_empty   = empty;
    bus.fifo_rd_data = (src.size() != 0) ? src[0] : W'($urandom);
    #1;
    free = !m_ov || rdy;
    pop  = !empty && ((held.size() < R - 1) || free);
    check_eq("rd_en", bus.fifo_rd_en, pop);
    if (empty) check_eq("rd_en_while_empty", bus.fifo_rd_en, 1'b0);
    check_eq("valid", bus.out_valid, m_ov);
    check_eq("busy", bus.busy, (held.size() != 0) || m_pend || m_ov);
    if (m_ov) begin
      check_eq("data", bus.out_data, m_od);
      check_eq("keep", bus.out_keep, m_keep);
    end
    if (bus.fifo_rd_en === 1'b1) dut_pops++;
    @(posedge rd_clk);
    pend = m_pend || fl;
    if (m_ov && rdy) m_ov = 1'b0;
    if (pop) held.push_back(src.pop_front());
    if ((held.size() == R) || (pend && free && (held.size() > 0))) begin
      m_od   = '0;
      m_keep = '0;
      foreach (held[i]) begin
        m_od[i*W +: W] = held[i];
        m_keep[i]      = 1'b1;
      end
      held.delete();
      m_ov = 1'b1;
      pend = 1'b0;
    end else if (held.size() == 0) begin
      pend = 1'b0;
    end
    m_pend = pend;
    #1;
  endtask

  task automatic do_reset();
    rd_reset = 1'b1;
    #1;
    check_eq("rst_valid", bus.out_valid, 1'b0);
    check_eq("rst_data", bus.out_data, '0);
    check_eq("rst_keep", bus.out_keep, '0);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_rd_en", bus.fifo_rd_en, 1'b0);
    held.delete();
    src.delete();
    m_pend = 1'b0;
    m_ov   = 1'b0;
    m_od   = '0;
    m_keep = '0;
    @(posedge rd_clk);
    #1;
    rd_reset = 1'b0;
    #1;
  endtask

  initial begin
    int p0;
    n_vec = 0; n_err = 0; dut_pops = 0;
    bus.out_ready = 1'b0; bus.flush = 1'b0;
    bus.fifo_empty = 1'b1; bus.fifo_rd_data = '0;
    rd_reset = 1'b0;
    #2;
    do_reset();

    // basic packing
    src.push_back(8'h11); src.push_back(8'h22); src.push_back(8'h33); src.push_back(8'h44);
    repeat (4) step(1, 0, 0);
    check_eq("basic_valid", bus.out_valid, 1'b1);
    check_eq("basic_data", bus.out_data, 32'h44332211);
    check_eq("basic_keep", bus.out_keep, 4'b1111);

    // backpressure: three more pops then stall
    push_words(7, 8'h51);
    p0 = dut_pops;
    repeat (6) step(0, 0, 0);
    check_eq("bp_pops", dut_pops - p0, 3);
    step(1, 0, 0);
    check_eq("bp_beat2_valid", bus.out_valid, 1'b1);
    check_eq("bp_beat2_data", bus.out_data, 32'h54535251);
    repeat (4) step(1, 0, 0);
    step(1, 1, 0);
    step(1, 0, 0);

    // partial flush
    src.push_back(8'hAA); src.push_back(8'hBB);
    repeat (2) step(1, 0, 0);
    step(1, 1, 0);
    check_eq("pflush_data", bus.out_data, 32'h0000BBAA);
    check_eq("pflush_keep", bus.out_keep, 4'b0011);
    step(1, 0, 0);
    check_eq("pflush_busy", bus.busy, 1'b0);

    // flush coincident with third pop
    src.push_back(8'hC1); src.push_back(8'hC2); src.push_back(8'hC3);
    repeat (2) step(1, 0, 0);
    step(1, 1, 0);
    check_eq("cflush_data", bus.out_data, 32'h00C3C2C1);
    check_eq("cflush_keep", bus.out_keep, 4'b0111);
    step(1, 0, 0);

    // flush with empty accumulator
    step(1, 1, 0);
    check_eq("eflush_valid", bus.out_valid, 1'b0);
    check_eq("eflush_busy", bus.busy, 1'b0);
    step(1, 0, 0);

    // alternating empty gaps
    push_words(8, -1);
    for (int i = 0; i < 16; i++) step(1, 0, i % 2 == 0);
    step(1, 0, 0);

    // reset mid-beat with two words held and an unaccepted beat
    push_words(6, 8'hA0);
    repeat (6) step(0, 0, 0);
    do_reset();
    push_words(4, 8'hB0);
    repeat (4) step(1, 0, 0);
    check_eq("post_rst_data", bus.out_data, 32'hB3B2B1B0);
    check_eq("post_rst_keep", bus.out_keep, 4'b1111);
    step(1, 0, 0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (src.size() < 4) push_words($urandom_range(1, 6), -1);
      if ($urandom_range(0, 499) == 0) do_reset();
      else step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
